test_status_monitor: RTL and testbench
======================================

Name: test_status_monitor

Overview:
- Synthesisable, parametrised successor to the simulation-only pass/fail check in the SoC bench.
- Watches NUM_CH hart register triplets: done flag (x26), result (x27) and test number (gp/x3).
- Per channel, decides PASS, FAIL or TIMEOUT and reports the elapsed cycle count.
- Sits beside RISCV_soc, either in FPGA top-level debug logic or as a bench checker; it only reads register values, never drives them.

Parameters:
- NUM_CH, 1, number of independently monitored harts/channels (1..8).
- XLEN, 32, width of each watched register.
- CNT_W, 32, width of each per-channel cycle counter.
- SETTLE_CYCLES, 2, cycles between done detection and result sampling (0..15).
- TIMEOUT_CYCLES, 100000, RUN cycles before TIMEOUT is declared; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; the same net used by RISCV_soc.
- clear_i  in  1  synchronous restart of all channels; priority over everything except rst.
- done_reg_i  in  NUM_CH*XLEN  packed x26 values; channel c occupies bits [c*XLEN +: XLEN].
- result_reg_i  in  NUM_CH*XLEN  packed x27 values.
- gp_reg_i  in  NUM_CH*XLEN  packed x3 (test number) values.
- busy_o  out  NUM_CH  channel in RUN or SETTLE.
- pass_o  out  NUM_CH  channel finished and passed.
- fail_o  out  NUM_CH  channel finished with result != 1.
- timeout_o  out  NUM_CH  channel hit TIMEOUT_CYCLES.
- cycles_o  out  NUM_CH*CNT_W  cycles spent in RUN, frozen at exit.
- fail_tnum_o  out  NUM_CH*XLEN  gp captured at FAIL (see Optional Feature).
- all_done_o  out  1  AND of all channels having left RUN/SETTLE.
- all_pass_o  out  1  all_done_o and every pass_o bit set.

Behaviour:
- Reset (rst=0, asynchronous): every channel enters RUN with counter 0.
  - busy_o = all ones.
  - pass_o, fail_o, timeout_o, cycles_o, fail_tnum_o, all_done_o, all_pass_o = 0.
- Per-channel FSM: RUN, SETTLE, PASS, FAIL, TIMEOUT. Outputs are registered and reflect the state after each edge.
- RUN:
  - Counter increments by 1 each cycle and saturates at 2^CNT_W-1.
  - done_reg == 1 exactly (any other value, including 0 or 2, is not done): go to SETTLE and freeze the counter.
  - Otherwise, if TIMEOUT_CYCLES != 0 and the post-increment counter equals TIMEOUT_CYCLES: go to TIMEOUT.
  - If done and timeout occur on the same cycle, done wins.
- SETTLE:
  - A wait counter counts SETTLE_CYCLES cycles, then the channel samples result_reg.
  - result == 1: go to PASS. Else: go to FAIL.
  - done is not re-checked during SETTLE (latched).
  - With SETTLE_CYCLES = 0, sampling happens on the cycle after entering SETTLE (one-cycle minimum).
- PASS, FAIL and TIMEOUT are terminal until clear_i or rst.
- Latency: pass_o/fail_o rise SETTLE_CYCLES+2 edges after the edge on which done becomes 1.
- clear_i = 1 at an edge: every channel returns to the reset values above, except that clear does not affect rst-only logic.
- cycles_o for a channel equals the number of RUN edges counted before exit.
- all_done_o / all_pass_o are registered from the next-state values, so they rise on the same edge as the last channel's status bit.
- Channels are fully independent; no arbitration is needed.

Optional Feature:
- Macro: TEST_STATUS_FAIL_CAPTURE_EN.
- Defined: on the SETTLE->FAIL transition, gp_reg for that channel is latched into fail_tnum_o and held until clear_i or rst.
- Not defined: fail_tnum_o is tied to 0, gp_reg_i is ignored, and no capture flops are built.

Decomposition:
- Package test_status_pkg holds:
  - the state encoding typedef (RUN=0, SETTLE=1, PASS=2, FAIL=3, TIMEOUT=4, 3 bits);
  - DONE_MAGIC = 1 and PASS_MAGIC = 1;
  - the settle-counter width constant (4).
- Sub-module test_status_channel implements one FSM, its counters and the capture logic.
- Top level is a generate loop over NUM_CH plus the all_done/all_pass reduction.

Test Plan:
- NUM_CH=1: release rst, hold done=0 for 50 cycles, then done=1 with result=1 -> SETTLE then PASS; pass_o=1 at edge 50+SETTLE_CYCLES+2; cycles_o=50; all_pass_o=1.
- done=1 with result=0 and gp=7, macro defined -> fail_o=1, fail_tnum_o=7, all_pass_o=0. Same run without the macro -> fail_tnum_o=0.
- TIMEOUT_CYCLES=20, done held at 0 -> timeout_o=1 after the 20th RUN edge; cycles_o=20; busy_o=0.
- NUM_CH=2: ch0 passes at cycle 10, ch1 fails at cycle 30 -> all_done_o rises with ch1's fail_o; all_pass_o stays 0. done=2 on ch0 is ignored.
- Reset and clear:
  - Assert rst mid-SETTLE -> outputs return to reset values immediately, without waiting for clk.
  - Assert clear_i after PASS -> busy_o=1 and cycles_o=0 on the next edge.
- CNT_W=4, TIMEOUT_CYCLES=0 -> counter saturates at 15 with no timeout; a later done gives PASS with cycles_o=15.

Source files
------------

// File: rtl/test_status_pkg.sv
// Shared types and constants for the test status monitor.
//   state_e      : per-channel FSM encoding (RUN=0, SETTLE=1, PASS=2, FAIL=3, TIMEOUT=4)
//   DONE_MAGIC   : value of the done register (x26) that marks end of test
//   PASS_MAGIC   : value of the result register (x27) that marks a passing test
//   SETTLE_CNT_W : width of the settle wait counter (SETTLE_CYCLES is 0..15)
package test_status_pkg;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StSettle  = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4
  } state_e;

  localparam int unsigned DONE_MAGIC   = 1;
  localparam int unsigned PASS_MAGIC   = 1;
  localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/test_status_channel.sv
// One monitored hart: RUN -> SETTLE -> PASS/FAIL, or RUN -> TIMEOUT.
// Optional macro TEST_STATUS_FAIL_CAPTURE_EN builds a register that latches the test
// number (gp) on the SETTLE->FAIL transition; without it fail_tnum_o is tied to zero.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   clear_i           : synchronous restart to the reset state
//   done_i/result_i/gp_i : watched x26 / x27 / x3 values
//   busy_o            : in RUN or SETTLE
//   pass_o/fail_o/timeout_o : terminal status
//   cycles_o          : RUN cycles counted, frozen on exit
//   fail_tnum_o       : gp captured at FAIL
//   finished_d_o/passed_d_o : next-state status, used by the top-level reduction
module test_status_channel
  import test_status_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [XLEN-1:0]  done_i,
  input  logic [XLEN-1:0]  result_i,
  input  logic [XLEN-1:0]  gp_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [XLEN-1:0]  fail_tnum_o,
  output logic             finished_d_o,
  output logic             passed_d_o
);

  localparam logic [CNT_W-1:0]        CntMax     = '1;
  localparam logic [SETTLE_CNT_W-1:0] SettleLast = SETTLE_CNT_W'(SETTLE_CYCLES);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [SETTLE_CNT_W-1:0] wait_q, wait_d;
  logic                    is_done, is_pass, hit_timeout, capture;

  assign is_done = (done_i == XLEN'(DONE_MAGIC));
  assign is_pass = (result_i == XLEN'(PASS_MAGIC));

  // Saturating increment; the timeout compare is done on the post-increment value.
  assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
  // Compare in 64 bits so a TIMEOUT_CYCLES wider than the counter simply never fires.
  assign hit_timeout = (TIMEOUT_CYCLES != 0) && (64'(cnt_inc) == 64'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    capture = 1'b0;
    if (clear_i) begin
      state_d = StRun;
      cnt_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        StRun: begin
          // Done wins over a simultaneous timeout; the counter freezes on exit.
          if (is_done) begin
            state_d = StSettle;
            wait_d  = '0;
          end else begin
            cnt_d = cnt_inc;
            if (hit_timeout) state_d = StTimeout;
          end
        end
        StSettle: begin
          // Done is not re-checked here; only the result is sampled once the wait expires.
          if (wait_q == SettleLast) begin
            state_d = is_pass ? StPass : StFail;
            capture = ~is_pass;
          end else begin
            wait_d = wait_q + SETTLE_CNT_W'(1);
          end
        end
        StPass, StFail, StTimeout: ;
        default: begin
          state_d = StRun;
          cnt_d   = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign busy_o       = (state_q == StRun) || (state_q == StSettle);
  assign pass_o       = (state_q == StPass);
  assign fail_o       = (state_q == StFail);
  assign timeout_o    = (state_q == StTimeout);
  assign cycles_o     = cnt_q;
  assign finished_d_o = (state_d == StPass) || (state_d == StFail) || (state_d == StTimeout);
  assign passed_d_o   = (state_d == StPass);

`ifdef TEST_STATUS_FAIL_CAPTURE_EN
  logic [XLEN-1:0] tnum_q, tnum_d;

  always_comb begin
    tnum_d = tnum_q;
    if (clear_i) begin
      tnum_d = '0;
    end else if (capture) begin
      tnum_d = gp_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tnum_q <= '0;
    end else begin
      tnum_q <= tnum_d;
    end
  end

  assign fail_tnum_o = tnum_q;
`else
  logic unused_capture;
  assign unused_capture = ^{gp_i, capture};
  assign fail_tnum_o    = '0;
`endif

endmodule

// File: rtl/test_status_monitor.sv
// Pass/fail/timeout monitor for NUM_CH harts, reading x26 (done), x27 (result) and
// x3 (test number). Read-only observer; it never drives the watched registers.
// Optional macro TEST_STATUS_FAIL_CAPTURE_EN enables capture of gp into fail_tnum_o.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset (shared with the SoC)
//   clear_i        : synchronous restart of every channel
//   done_reg_i, result_reg_i, gp_reg_i : packed per-channel values, channel c at [c*XLEN +: XLEN]
//   busy_o, pass_o, fail_o, timeout_o  : per-channel status bits
//   cycles_o       : per-channel RUN cycle counts, packed at [c*CNT_W +: CNT_W]
//   fail_tnum_o    : per-channel captured test number
//   all_done_o     : every channel has left RUN/SETTLE
//   all_pass_o     : every channel passed
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic [NUM_CH*XLEN-1:0]  done_reg_i,
  input  logic [NUM_CH*XLEN-1:0]  result_reg_i,
  input  logic [NUM_CH*XLEN-1:0]  gp_reg_i,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       pass_o,
  output logic [NUM_CH-1:0]       fail_o,
  output logic [NUM_CH-1:0]       timeout_o,
  output logic [NUM_CH*CNT_W-1:0] cycles_o,
  output logic [NUM_CH*XLEN-1:0]  fail_tnum_o,
  output logic                    all_done_o,
  output logic                    all_pass_o
);

  logic [NUM_CH-1:0] finished_d, passed_d;
  logic              all_done_q, all_done_d, all_pass_q, all_pass_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    test_status_channel #(
      .XLEN          (XLEN),
      .CNT_W         (CNT_W),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (clear_i),
      .done_i      (done_reg_i[c*XLEN +: XLEN]),
      .result_i    (result_reg_i[c*XLEN +: XLEN]),
      .gp_i        (gp_reg_i[c*XLEN +: XLEN]),
      .busy_o      (busy_o[c]),
      .pass_o      (pass_o[c]),
      .fail_o      (fail_o[c]),
      .timeout_o   (timeout_o[c]),
      .cycles_o    (cycles_o[c*CNT_W +: CNT_W]),
      .fail_tnum_o (fail_tnum_o[c*XLEN +: XLEN]),
      .finished_d_o(finished_d[c]),
      .passed_d_o  (passed_d[c])
    );
  end

  // Built from next-state values so the summary bits rise with the last channel's status.
  // A clear forces every channel to RUN, which drops both bits on the same edge.
  assign all_done_d = &finished_d;
  assign all_pass_d = &passed_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      all_done_q <= 1'b0;
      all_pass_q <= 1'b0;
    end else begin
      all_done_q <= all_done_d;
      all_pass_q <= all_pass_d;
    end
  end

  assign all_done_o = all_done_q;
  assign all_pass_o = all_pass_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench: three monitor instances sharing clock, reset and clear.
//   A: 2 channels, settle 2, timeout 100000 (pass/fail/all_done, clear, async reset)
//   B: 1 channel, 4-bit counter, settle 0, no timeout (saturation)
//   C: 1 channel, settle 1, timeout 20
module tb_test_status_monitor;

  logic clk;
  logic rst;
  logic clear;

  logic [63:0]  a_done, a_res, a_gp;
  logic [1:0]   a_busy, a_pass, a_fail, a_tmo;
  logic [63:0]  a_cyc, a_tnum;
  logic         a_all_done, a_all_pass;

  logic [31:0]  b_done, b_res, b_gp;
  logic         b_busy, b_pass, b_fail, b_tmo;
  logic [3:0]   b_cyc;
  logic [31:0]  b_tnum;
  logic         b_all_done, b_all_pass;

  logic [31:0]  c_done, c_res, c_gp;
  logic         c_busy, c_pass, c_fail, c_tmo;
  logic [31:0]  c_cyc, c_tnum;
  logic         c_all_done, c_all_pass;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef TEST_STATUS_FAIL_CAPTURE_EN
  localparam logic [31:0] ExpTnum = 32'd7;
`else
  localparam logic [31:0] ExpTnum = 32'd0;
`endif

  test_status_monitor #(
    .NUM_CH(2), .XLEN(32), .CNT_W(32), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(100000)
  ) u_dut_a (
    .clk(clk), .rst(rst), .clear_i(clear),
    .done_reg_i(a_done), .result_reg_i(a_res), .gp_reg_i(a_gp),
    .busy_o(a_busy), .pass_o(a_pass), .fail_o(a_fail), .timeout_o(a_tmo),
    .cycles_o(a_cyc), .fail_tnum_o(a_tnum), .all_done_o(a_all_done), .all_pass_o(a_all_pass)
  );

  test_status_monitor #(
    .NUM_CH(1), .XLEN(32), .CNT_W(4), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .clear_i(clear),
    .done_reg_i(b_done), .result_reg_i(b_res), .gp_reg_i(b_gp),
    .busy_o(b_busy), .pass_o(b_pass), .fail_o(b_fail), .timeout_o(b_tmo),
    .cycles_o(b_cyc), .fail_tnum_o(b_tnum), .all_done_o(b_all_done), .all_pass_o(b_all_pass)
  );

  test_status_monitor #(
    .NUM_CH(1), .XLEN(32), .CNT_W(32), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(20)
  ) u_dut_c (
    .clk(clk), .rst(rst), .clear_i(clear),
    .done_reg_i(c_done), .result_reg_i(c_res), .gp_reg_i(c_gp),
    .busy_o(c_busy), .pass_o(c_pass), .fail_o(c_fail), .timeout_o(c_tmo),
    .cycles_o(c_cyc), .fail_tnum_o(c_tnum), .all_done_o(c_all_done), .all_pass_o(c_all_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    clear  = 1'b0;
    a_done = '0; a_res = '0; a_gp = '0;
    b_done = '0; b_res = '0; b_gp = '0;
    c_done = '0; c_res = '0; c_gp = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_a_busy",     64'(a_busy),     64'h3);
    check("rst_a_pass",     64'(a_pass),     64'h0);
    check("rst_a_fail",     64'(a_fail),     64'h0);
    check("rst_a_timeout",  64'(a_tmo),      64'h0);
    check("rst_a_cycles",   a_cyc,           64'h0);
    check("rst_a_tnum",     a_tnum,          64'h0);
    check("rst_a_all_done", 64'(a_all_done), 64'h0);
    check("rst_a_all_pass", 64'(a_all_pass), 64'h0);

    // Release reset away from the clock edge; the next posedge is E1.
    @(negedge clk);
    a_done = {32'd0, 32'd2};       // ch0 done=2 must be ignored
    a_res  = {32'd0, 32'd1};       // ch0 passes, ch1 fails
    a_gp   = {32'd7, 32'd5};
    b_res  = 32'd1;
    rst    = 1'b1;

    step(5);                                            // E5
    check("a_done2_ignored_busy", 64'(a_busy), 64'h3);
    check("a_ch0_cycles_e5", 64'(a_cyc[31:0]), 64'd5);
    check("c_cycles_e5", 64'(c_cyc), 64'd5);

    step(5);                                            // E10
    a_done[31:0] = 32'd1;
    step(3);                                            // E13: SETTLE+wait
    check("a_ch0_pass_early", 64'(a_pass), 64'h0);
    check("a_ch0_busy_settle", 64'(a_busy), 64'h3);
    step(1);                                            // E14 = 10+2+2
    check("a_ch0_pass", 64'(a_pass), 64'h1);
    check("a_ch0_busy_off", 64'(a_busy), 64'h2);
    check("a_ch0_cycles", 64'(a_cyc[31:0]), 64'd10);
    check("a_all_done_partial", 64'(a_all_done), 64'h0);
    check("b_cycles_e14", 64'(b_cyc), 64'd14);

    step(5);                                            // E19
    check("c_no_timeout_e19", 64'(c_tmo), 64'h0);
    check("c_cycles_e19", 64'(c_cyc), 64'd19);
    step(1);                                            // E20
    check("c_timeout", 64'(c_tmo), 64'h1);
    check("c_timeout_cycles", 64'(c_cyc), 64'd20);
    check("c_timeout_busy", 64'(c_busy), 64'h0);
    check("b_saturated", 64'(b_cyc), 64'd15);
    check("b_no_timeout", 64'(b_tmo), 64'h0);
    check("b_busy_sat", 64'(b_busy), 64'h1);
    b_done = 32'd1;
    step(2);                                            // E22 = 20+0+2
    check("b_pass", 64'(b_pass), 64'h1);
    check("b_pass_cycles", 64'(b_cyc), 64'd15);
    check("b_all_pass", 64'(b_all_pass), 64'h1);
    check("c_cycles_frozen", 64'(c_cyc), 64'd20);

    step(8);                                            // E30
    a_done[63:32] = 32'd1;
    step(3);                                            // E33
    check("a_ch1_fail_early", 64'(a_fail), 64'h0);
    check("a_all_done_early", 64'(a_all_done), 64'h0);
    step(1);                                            // E34 = 30+2+2
    check("a_ch1_fail", 64'(a_fail), 64'h2);
    check("a_ch1_cycles", 64'(a_cyc[63:32]), 64'd30);
    check("a_all_done", 64'(a_all_done), 64'h1);
    check("a_all_pass_fail", 64'(a_all_pass), 64'h0);
    check("a_ch1_tnum", 64'(a_tnum[63:32]), 64'(ExpTnum));
    check("a_ch0_tnum", 64'(a_tnum[31:0]), 64'h0);
    check("a_ch0_pass_held", 64'(a_pass), 64'h1);

    // Clear after PASS/FAIL; both channels then pass after 50 RUN cycles.
    clear  = 1'b1;
    a_done = '0;
    a_res  = {32'd1, 32'd1};
    b_done = '0;
    step(1);                                            // E35
    clear = 1'b0;
    check("clr_a_busy", 64'(a_busy), 64'h3);
    check("clr_a_cycles", a_cyc, 64'h0);
    check("clr_a_pass", 64'(a_pass), 64'h0);
    check("clr_a_fail", 64'(a_fail), 64'h0);
    check("clr_a_tnum", a_tnum, 64'h0);
    check("clr_a_all_done", 64'(a_all_done), 64'h0);
    check("clr_b_busy", 64'(b_busy), 64'h1);
    check("clr_c_timeout", 64'(c_tmo), 64'h0);

    step(50);                                           // E85
    check("a_cycles_50", a_cyc, {32'd50, 32'd50});
    a_done = {32'd1, 32'd1};
    step(3);                                            // E88
    check("a_pass50_early", 64'(a_pass), 64'h0);
    step(1);                                            // E89 = 85+2+2
    check("a_pass50", 64'(a_pass), 64'h3);
    check("a_pass50_cycles", a_cyc, {32'd50, 32'd50});
    check("a_all_done_pass", 64'(a_all_done), 64'h1);
    check("a_all_pass", 64'(a_all_pass), 64'h1);

    // Enter SETTLE with a nonzero count, then pulse reset between edges.
    clear  = 1'b1;
    a_done = '0;
    step(1);                                            // E90
    clear = 1'b0;
    check("clr2_a_all_pass", 64'(a_all_pass), 64'h0);
    step(5);                                            // E95
    a_done = {32'd1, 32'd1};
    step(2);                                            // E97: SETTLE
    check("a_settle_cycles", a_cyc, {32'd5, 32'd5});
    check("c_cycles_e97", 64'(c_cyc), 64'd7);
    #1 rst = 1'b0;
    #1;
    check("async_a_cycles", a_cyc, 64'h0);
    check("async_a_busy", 64'(a_busy), 64'h3);
    check("async_a_pass", 64'(a_pass), 64'h0);
    check("async_b_cycles", 64'(b_cyc), 64'd0);
    check("async_c_cycles", 64'(c_cyc), 64'd0);

    @(negedge clk);
    rst = 1'b1;
    step(4);                                            // done held: SETTLE at 1, PASS at 4
    check("post_rst_pass", 64'(a_pass), 64'h3);
    check("post_rst_cycles", a_cyc, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
